ifc_arbiter: RTL and testbench
==============================

# ifc_arbiter

Round-robin scheduler that shares one `IfcEnt` combinational datapath among `NREQ` requesters. Each requester presents an operand set (A, B, X, Y, Q) with a valid/ready handshake. The arbiter grants one requester at a time, latches its operands into registers that drive the `IfcEnt` instance, registers the resulting Z and returns it with the requester index on a single response channel.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; 2..16.
- `IDW`, `$clog2(NREQ)`: response ID width; derived, not overridden.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `REQ_VALID`  in  NREQ  per-requester request valid.
- `REQ_READY`  out  NREQ  per-requester accept; one-hot or zero.
- `REQ_A`, `REQ_B`  in  uint(NREQ, 8)  operand A/B arrays.
- `REQ_X`, `REQ_Y`  in  uint(NREQ, 16)  interface X/Y arrays.
- `REQ_Q`  in  uint(NREQ, 8)  interface Q array.
- `RSP_VALID`  out  1  response valid.
- `RSP_READY`  in  1  response consumer ready.
- `RSP_Z`  out  8  result.
- `RSP_ID`  out  IDW  index of the granted requester.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP. The round-robin pointer `PTR` (IDW bits) gives the highest-priority requester.
- **IDLE:**
  - If any `REQ_VALID` bit is set, the winner is the first set bit scanning `PTR`, `PTR+1`, … modulo NREQ.
  - `REQ_READY[winner]` is driven high combinationally in the same cycle. That cycle is the request handshake.
  - The winner's A/B/X/Y/Q are latched into the operand registers, `GRANT_ID` is set to the winner, and the FSM moves to EXEC.
  - With no valid request, the FSM stays in IDLE and `REQ_READY` is 0.
- **EXEC:**
  - The operand registers drive `IfcEnt`.
  - At the end of the cycle, Z is captured into `RSP_Z`, `GRANT_ID` into `RSP_ID`, `RSP_VALID` is set to 1, and the FSM moves to RESP.
- **RESP:**
  - `RSP_VALID`, `RSP_Z` and `RSP_ID` are held stable until `RSP_READY` is high.
  - On the response handshake: `RSP_VALID` drops to 0, `PTR` becomes `GRANT_ID+1` (wrapping NREQ-1 to 0), and the FSM returns to IDLE.
- `REQ_READY` is 0 in EXEC and RESP. Requests are never accepted while a job is outstanding.
- Arithmetic is the `IfcEnt` result: Z = low 8 bits of ( zero-extend-to-16((A&B)|(A^B)) | ((X+Y) − zext16(Q)) ).
  - X+Y and the subtraction wrap modulo 2^16. No saturation, no overflow flag.
- A requester may deassert `REQ_VALID` before being granted. This must not cause a grant or any state change.
- If `REQ_VALID` falls in the same cycle the arbiter would grant it, that requester is simply not selected; the scan proceeds to the next set bit.
- `RSP_READY` already high when RESP is entered completes the response handshake in that first RESP cycle.
- Asynchronous reset, including mid-operation:
  - FSM goes to IDLE, `PTR`=0, operand registers 0, `GRANT_ID`=0.
  - `REQ_READY`=0, `RSP_VALID`=0, `RSP_Z`=0, `RSP_ID`=0, `BUSY`=0.
  - Any in-flight job is dropped; no response is emitted after reset releases.

## Timing
- A request accepted in cycle N gives `RSP_VALID` high from cycle N+2.
- With `RSP_READY` held high, the next request is accepted at N+3. Peak throughput is 1 job per 3 cycles.
- `RSP_*` are registered outputs. `REQ_READY` and `BUSY` are combinational from FSM state and `REQ_VALID`.
- The `IfcEnt` combinational path sees only registered inputs. The critical path is register → 16-bit add/sub → `RSP_Z` register.
- Fairness: any continuously asserted request is granted within NREQ jobs.

## Structure
- Package `ifc_arb_pkg` holds:
  - `DW`=8 and `XW`=16 constants.
  - State enum `ifc_arb_state_t` {IDLE, EXEC, RESP}.
  - Function `rr_pick(valid, ptr)` returning the winner index and a found flag.
- Sub-module: one instance of the existing `IfcEnt`, ports bound to the operand registers. `IfcEnt` is not modified.
- Pointer, FSM, operand and result registers all live in a single `always_ff @(posedge CLK or negedge RST_N)` block.

## Test plan
- Reset then single job: NREQ=4, requester 2 with A=0x01, B=0x02, X=0x10, Y=0x20, Q=0 → handshake at N; `RSP_VALID` at N+2 with Z=0x33, ID=2; `PTR`=3 after the response handshake.
- Wrap-around arithmetic: A=B=0, X=0xFFFF, Y=1, Q=1 → Z=0xFF; A=B=0, X=Y=0, Q=1 → Z=0xFF; A=0x0F, B=0xF0, X=17, Y=21, Q=3 → Z=0xFF.
- Round-robin: all four `REQ_VALID` held high, `RSP_READY`=1 → grant order 0,1,2,3,0; a new grant every 3 cycles.
- Backpressure: `RSP_READY`=0 for 5 cycles in RESP → `RSP_Z`/`RSP_ID` stable, `REQ_READY` all 0, `BUSY`=1; `RSP_READY`=1 → IDLE on the next cycle.
- Reset mid-operation: assert `RST_N`=0 during EXEC → all outputs 0 immediately; after release with no requests, `RSP_VALID` stays 0 for 10 cycles.
- Withdrawn request: requester 1 pulses `REQ_VALID` for 1 cycle while the FSM is in RESP → never granted, no response carries ID=1.

Source files
------------

// File: rtl/ifc_arbiter_pkg.sv
// Shared types, widths and the round-robin pick helper for the IfcEnt arbiter.
package ifc_arb_pkg;

  localparam int DW     = 8;   // operand A/B/Q and result width
  localparam int XW     = 16;  // interface X/Y width
  localparam int MAXREQ = 16;  // largest supported requester count
  localparam int PW     = 4;   // index width covering MAXREQ

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ifc_arb_state_t;

  typedef struct packed {
    logic          found;
    logic [PW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0] scanning from ptr upward, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                       input logic [PW-1:0]     ptr,
                                       input int                n);
    rr_pick_t r;
    int       pos;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < MAXREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= n) pos = pos - n;
      if ((k < n) && !r.found && valid[pos[PW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = pos[PW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ifc_arbiter_ent.sv
// IfcEnt: combinational datapath shared by all requesters.
// Z = low byte of ( zext16((A&B)|(A^B)) | ((X+Y) - zext16(Q)) ), all mod 2^16.
module IfcEnt (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic [7:0]  Q,
  output logic [7:0]  Z
);

  assign Z = 8'({8'b0, ((A & B) | (A ^ B))} | (X + Y - {8'b0, Q}));

endmodule

// File: rtl/ifc_arbiter.sv
// Round-robin scheduler sharing one IfcEnt datapath among NREQ requesters.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; winner accepted combinationally
// EXEC  | operand registers drive IfcEnt; result captured at cycle end
// RESP  | response held on RSP_* until RSP_READY, then pointer advances
module ifc_arbiter
  import ifc_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ_VALID,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [NREQ*8-1:0] REQ_A,
  input  logic [NREQ*8-1:0] REQ_B,
  input  logic [NREQ*16-1:0] REQ_X,
  input  logic [NREQ*16-1:0] REQ_Y,
  input  logic [NREQ*8-1:0] REQ_Q,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [7:0]        RSP_Z,
  output logic [IDW-1:0]    RSP_ID,
  output logic              BUSY
);

  ifc_arb_state_t  state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  grant_id_q;
  logic [DW-1:0]   a_q, b_q, q_q;
  logic [XW-1:0]   x_q, y_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_z_q;
  logic [IDW-1:0]  rsp_id_q;

  logic [MAXREQ-1:0] valid_ext;
  logic [PW-1:0]     ptr_ext;
  rr_pick_t          pick;
  logic [IDW-1:0]    ptr_d;
  logic [DW-1:0]     ent_z;

  // Widen request vector and pointer to the helper's fixed width, then pick.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = REQ_VALID;
    ptr_ext               = '0;
    ptr_ext[IDW-1:0]      = ptr_q;
    pick                  = rr_pick(valid_ext, ptr_ext, NREQ);
  end

  // Pointer moves past the requester just served, wrapping at NREQ-1.
  always_comb begin
    ptr_d = grant_id_q + IDW'(1);
    if (grant_id_q == IDW'(NREQ - 1)) ptr_d = '0;
  end

  // Accept is only offered in IDLE; gated by reset so it reads 0 while held in reset.
  always_comb begin
    REQ_READY = '0;
    if ((state_q == IDLE) && pick.found && RST_N) REQ_READY = NREQ'(1) << pick.idx;
  end

  assign BUSY      = (state_q != IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_Z     = rsp_z_q;
  assign RSP_ID    = rsp_id_q;

  IfcEnt u_ent (
    .A (a_q),
    .B (b_q),
    .X (x_q),
    .Y (y_q),
    .Q (q_q),
    .Z (ent_z)
  );

  // FSM, pointer, operand and response registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      q_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick.found) begin
            a_q        <= REQ_A[8*pick.idx +: 8];
            b_q        <= REQ_B[8*pick.idx +: 8];
            x_q        <= REQ_X[16*pick.idx +: 16];
            y_q        <= REQ_Y[16*pick.idx +: 16];
            q_q        <= REQ_Q[8*pick.idx +: 8];
            grant_id_q <= pick.idx[IDW-1:0];
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          rsp_z_q     <= ent_z;
          rsp_id_q    <= grant_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifc_arbiter.sv
// Directed bench for ifc_arbiter (NREQ=4) with hand-computed expectations.
module tb_ifc_arbiter;

  localparam int NREQ = 4;

  logic          CLK;
  logic          RST_N;
  logic [3:0]    REQ_VALID;
  logic [3:0]    REQ_READY;
  logic [31:0]   REQ_A, REQ_B, REQ_Q;
  logic [63:0]   REQ_X, REQ_Y;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [7:0]    RSP_Z;
  logic [1:0]    RSP_ID;
  logic          BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  ifc_arbiter #(.NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_X     (REQ_X),
    .REQ_Y     (REQ_Y),
    .REQ_Q     (REQ_Q),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_Z     (RSP_Z),
    .RSP_ID    (RSP_ID),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] x, input logic [15:0] y, input logic [7:0] q);
    REQ_A[8*id +: 8]   = a;
    REQ_B[8*id +: 8]   = b;
    REQ_X[16*id +: 16] = x;
    REQ_Y[16*id +: 16] = y;
    REQ_Q[8*id +: 8]   = q;
  endtask

  // One full job with RSP_READY high: handshake, EXEC, RESP, back to IDLE.
  task automatic run_job(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] x, input logic [15:0] y, input logic [7:0] q,
                         input logic [7:0] exp_z);
    set_ops(id, a, b, x, y, q);
    RSP_READY = 1'b1;
    REQ_VALID = 4'(1 << id);
    #1;
    chk("hs_ready", 32'(REQ_READY), 32'(1 << id));
    step();
    REQ_VALID = 4'b0;
    #1;
    chk("exec_busy", 32'(BUSY), 32'd1);
    chk("exec_rspv", 32'(RSP_VALID), 32'd0);
    step();
    chk("resp_valid", 32'(RSP_VALID), 32'd1);
    chk("resp_z", 32'(RSP_Z), 32'(exp_z));
    chk("resp_id", 32'(RSP_ID), 32'(id));
    step();
    chk("idle_rspv", 32'(RSP_VALID), 32'd0);
    chk("idle_busy", 32'(BUSY), 32'd0);
  endtask

  task automatic do_reset();
    #1;
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    step();
  endtask

  initial begin
    RST_N     = 1'b0;
    REQ_VALID = '0;
    REQ_A = '0; REQ_B = '0; REQ_Q = '0; REQ_X = '0; REQ_Y = '0;
    RSP_READY = 1'b0;
    step();
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    chk("rst_rspv", 32'(RSP_VALID), 32'd0);
    chk("rst_z", 32'(RSP_Z), 32'd0);
    chk("rst_id", 32'(RSP_ID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST_N = 1'b1;
    step();
    chk("idle_noreq_ready", 32'(REQ_READY), 32'd0);
    step();
    chk("idle_noreq_busy", 32'(BUSY), 32'd0);

    // Single job on requester 2: Z = 0x03 | 0x30 = 0x33.
    run_job(2, 8'h01, 8'h02, 16'h0010, 16'h0020, 8'h00, 8'h33);
    // Pointer is now 3: with all valid, requester 3 wins.
    REQ_VALID = 4'hF;
    #1;
    chk("ptr_after_2", 32'(REQ_READY), 32'h8);
    REQ_VALID = 4'h0;
    #1;
    chk("ready_drops", 32'(REQ_READY), 32'h0);

    // Wrap-around arithmetic.
    run_job(3, 8'h00, 8'h00, 16'hFFFF, 16'h0001, 8'h01, 8'hFF);
    run_job(0, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h01, 8'hFF);
    run_job(1, 8'h0F, 8'hF0, 16'd17, 16'd21, 8'h03, 8'hFF);
    run_job(2, 8'h10, 8'h00, 16'h0100, 16'h0005, 8'h02, 8'h13);

    // Round-robin from pointer 0 with all requests held.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i), 8'h00, 16'h0000, 16'h0000, 8'h00);
    REQ_VALID = 4'hF;
    RSP_READY = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("rr_grant", 32'(REQ_READY), 32'(1 << (j % 4)));
      step();
      chk("rr_exec_ready", 32'(REQ_READY), 32'd0);
      step();
      chk("rr_resp_id", 32'(RSP_ID), 32'(j % 4));
      chk("rr_resp_z", 32'(RSP_Z), 32'(j % 4));
      chk("rr_resp_ready", 32'(REQ_READY), 32'd0);
      step();
    end
    REQ_VALID = 4'h0;

    // Backpressure with a withdrawn request from requester 1 during RESP.
    do_reset();
    set_ops(0, 8'h05, 8'h00, 16'h0000, 16'h0000, 8'h00);
    set_ops(2, 8'h00, 8'h00, 16'h0040, 16'h0002, 8'h00);
    RSP_READY = 1'b0;
    REQ_VALID = 4'b0001;
    step();
    REQ_VALID = 4'b0100;
    step();
    for (int k = 0; k < 5; k++) begin
      REQ_VALID = (k == 2) ? 4'b0110 : 4'b0100;
      #1;
      chk("bp_rspv", 32'(RSP_VALID), 32'd1);
      chk("bp_z", 32'(RSP_Z), 32'h05);
      chk("bp_id", 32'(RSP_ID), 32'd0);
      chk("bp_ready", 32'(REQ_READY), 32'd0);
      chk("bp_busy", 32'(BUSY), 32'd1);
      step();
    end
    RSP_READY = 1'b1;
    step();
    chk("bp_release_busy", 32'(BUSY), 32'd0);
    chk("bp_release_rspv", 32'(RSP_VALID), 32'd0);
    chk("skip_withdrawn", 32'(REQ_READY), 32'b0100);
    step();
    REQ_VALID = 4'b0;
    step();
    chk("after_bp_id", 32'(RSP_ID), 32'd2);
    chk("after_bp_z", 32'(RSP_Z), 32'h42);
    step();

    // Reset during EXEC with a request still presented.
    set_ops(3, 8'hAA, 8'h00, 16'h0000, 16'h0000, 8'h00);
    REQ_VALID = 4'b1000;
    step();
    chk("pre_rst_busy", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(REQ_READY), 32'd0);
    chk("mid_rst_rspv", 32'(RSP_VALID), 32'd0);
    chk("mid_rst_z", 32'(RSP_Z), 32'd0);
    chk("mid_rst_id", 32'(RSP_ID), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    REQ_VALID = 4'b0;
    step();
    RST_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("post_rst_quiet", 32'(RSP_VALID), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
